// File: rtl/timera_iv_arbiter.sv
// TimerA interrupt vector arbiter: merges TAIFG and CCR1..CCR(N-1) flags into INT1,
// serves TAxIV and clears the highest-priority pending source once per access.
module timera_iv_arbiter #(
   parameter int          N_CCR   = 7,
   parameter logic [15:0] IV_ADDR = 16'h036E
) (
   input  logic             MCLK,
   input  logic             reset,
   input  logic [15:0]      MAB,
   input  logic [15:0]      MDBwrite,
   input  logic             MW,
   input  logic             BW,
   input  logic             TAIFG,
   input  logic             TAIE,
   input  logic [N_CCR-2:0] CCIFG,
   input  logic [N_CCR-2:0] CCIE,
   output logic             INT1,
   output logic             TAIFGclr,
   output logic [N_CCR-2:0] CCIFGclr,
   output logic [15:0]      MDBread
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t             r_state;
   logic [15:0]        r_snap;
   logic               r_taifgclr;
   logic [N_CCR-2:0]   r_ccifgclr;

   logic [N_CCR-2:0]   w_pend;
   logic               w_pt;
   logic               w_match;
   logic [15:0]        w_live_iv;
   logic [N_CCR-2:0]   w_sel_cc;
   logic               w_sel_t;
   logic [15:0]        w_mdb;
   logic               w_unused_bus;

   // Write data, strobes and the byte lane bit do not influence the vector; any hit is an access.
   assign w_unused_bus = ^{MDBwrite, MW, BW, MAB[0]};

   assign w_pend  = CCIFG & CCIE;
   assign w_pt    = TAIFG & TAIE;
   assign w_match = (MAB[15:1] == IV_ADDR[15:1]);
   assign INT1    = (|w_pend) | w_pt;

   // Lowest-index pending CCR wins; the timer overflow is the lowest priority source.
   assign w_sel_cc = w_pend & (~w_pend + {{(N_CCR-2){1'b0}}, 1'b1});
   assign w_sel_t  = w_pt & ~(|w_pend);

   // Live vector value: scan from the lowest priority so the last hit is the winner.
   always_comb begin
      w_live_iv = 16'h0000;
      if (w_pt) begin
         w_live_iv = 16'h000E;
      end else begin
         w_live_iv = 16'h0000;
      end
      for (int i = N_CCR - 1; i >= 1; i--) begin
         if (w_pend[i-1]) begin
            w_live_iv = 16'(2 * i);
         end else begin
            w_live_iv = w_live_iv;
         end
      end
   end

   // Read path: the first cycle of an access shows the live value, later cycles the held snapshot.
   always_comb begin
      w_mdb = 16'h0000;
      if (!w_match) begin
         w_mdb = 16'h0000;
      end else if (r_state == S_HOLD) begin
         w_mdb = r_snap;
      end else begin
         w_mdb = w_live_iv;
      end
   end

   // Access FSM: one snapshot and one clear strobe per contiguous dwell on the vector address.
   always_ff @(posedge MCLK) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_snap     <= 16'h0000;
         r_taifgclr <= 1'b0;
         r_ccifgclr <= {(N_CCR-1){1'b0}};
      end else begin
         r_taifgclr <= 1'b0;
         r_ccifgclr <= {(N_CCR-1){1'b0}};
         case (r_state)
            S_IDLE: begin
               if (w_match) begin
                  r_state    <= S_HOLD;
                  r_snap     <= w_live_iv;
                  r_taifgclr <= w_sel_t;
                  r_ccifgclr <= w_sel_cc;
               end
            end
            S_HOLD: begin
               if (!w_match) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign TAIFGclr = r_taifgclr;
   assign CCIFGclr = r_ccifgclr;
   assign MDBread  = w_mdb;

endmodule

// File: tb/tb_timera_iv_arbiter.sv
// Bench for timera_iv_arbiter: directed scenarios then random traffic, checked cycle by cycle
// against a transaction-level model of vector priority and one-clear-per-access.
module tb_timera_iv_arbiter;

   localparam logic [15:0] IVA = 16'h036E;

   logic        MCLK = 1'b0;
   logic        reset;
   logic [15:0] MAB;
   logic [15:0] MDBwrite;
   logic        MW;
   logic        BW;
   logic        TAIFG;
   logic        TAIE;
   logic [5:0]  CCIFG;
   logic [5:0]  CCIE;
   logic        INT1;
   logic        TAIFGclr;
   logic [5:0]  CCIFGclr;
   logic [15:0] MDBread;

   int          checks = 0;
   int          errors = 0;
   bit          prev_m;
   logic [15:0] snap_m;
   logic        exp_t;
   logic [5:0]  exp_cc;

   timera_iv_arbiter #(.N_CCR(7), .IV_ADDR(IVA)) dut (
      .MCLK(MCLK), .reset(reset), .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW),
      .TAIFG(TAIFG), .TAIE(TAIE), .CCIFG(CCIFG), .CCIE(CCIE), .INT1(INT1),
      .TAIFGclr(TAIFGclr), .CCIFGclr(CCIFGclr), .MDBread(MDBread)
   );

   always #5 MCLK = ~MCLK;

   function automatic logic [15:0] ref_iv(input logic [5:0] f, input logic [5:0] e,
                                          input logic tf, input logic te);
      for (int i = 1; i <= 6; i++) begin
         if (f[i-1] && e[i-1]) return 16'(2 * i);
      end
      return (tf && te) ? 16'h000E : 16'h0000;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive bus, check outputs, let the flag sources react to strobes.
   task automatic cycle(input bit m, input bit r, input bit wr);
      logic [15:0] live;
      logic [15:0] a;
      if (m) begin
         a = {IVA[15:1], 1'($urandom)};
      end else begin
         a = 16'($urandom);
         if (a[15:1] == IVA[15:1]) a[4] = ~a[4];
      end
      MAB      = a;
      MDBwrite = 16'($urandom);
      MW       = wr ? 1'b1 : 1'($urandom);
      BW       = wr ? 1'b1 : 1'($urandom);
      reset    = r;
      #1;
      live = ref_iv(CCIFG, CCIE, TAIFG, TAIE);
      chk("INT1", 16'(INT1), 16'(((CCIFG & CCIE) != 6'b0) || (TAIFG && TAIE)));
      chk("MDBread", MDBread, !m ? 16'h0000 : (prev_m ? snap_m : live));
      chk("TAIFGclr", 16'(TAIFGclr), 16'(exp_t));
      chk("CCIFGclr", 16'(CCIFGclr), 16'(exp_cc));
      CCIFG = CCIFG & ~CCIFGclr;
      if (TAIFGclr) TAIFG = 1'b0;
      live = ref_iv(CCIFG, CCIE, TAIFG, TAIE);
      if (m && !prev_m && !r) begin
         snap_m = live;
         exp_t  = (live == 16'h000E);
         exp_cc = (live >= 16'd2 && live <= 16'd12) ? 6'(1 << (live / 2 - 1)) : 6'b0;
      end else begin
         exp_t  = 1'b0;
         exp_cc = 6'b0;
      end
      prev_m = m && !r;
      @(posedge MCLK);
      #1;
   endtask

   task automatic clear_sources();
      CCIFG = 6'b0; CCIE = 6'b0; TAIFG = 1'b0; TAIE = 1'b0;
   endtask

   initial begin
      int run;
      bit m;
      reset = 1'b1; MAB = 16'h0000; MDBwrite = 16'h0000; MW = 1'b0; BW = 1'b0;
      clear_sources();
      prev_m = 1'b0; snap_m = 16'h0000; exp_t = 1'b0; exp_cc = 6'b0;
      repeat (2) @(posedge MCLK);
      #1;
      chk("rst_TAIFGclr", 16'(TAIFGclr), 16'h0000);
      chk("rst_CCIFGclr", 16'(CCIFGclr), 16'h0000);
      chk("rst_MDBread", MDBread, 16'h0000);
      chk("rst_INT1", 16'(INT1), 16'h0000);

      // 1: three-cycle read of the overflow vector
      TAIFG = 1'b1; TAIE = 1'b1;
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t1_INT1_low", 16'(INT1), 16'h0000);

      // 2: three sources drained in priority order, then an empty read
      CCIFG = 6'b000110; CCIE = 6'b111111; TAIFG = 1'b1; TAIE = 1'b1;
      repeat (4) begin
         cycle(1'b1, 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 1'b0);
      end
      chk("t2_drained", 16'(INT1), 16'h0000);

      // 3: disabled CCR1 flag is ignored
      clear_sources();
      CCIFG = 6'b000001; TAIFG = 1'b1; TAIE = 1'b1;
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t3_ccr1_kept", 16'(CCIFG), 16'h0001);

      // 4: byte write to the vector counts as an access
      clear_sources();
      CCIFG = 6'b000100; CCIE = 6'b111111;
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);

      // 5: CCR5 rises during a held access on CCR1
      clear_sources();
      CCIFG = 6'b000001; CCIE = 6'b111111;
      cycle(1'b1, 1'b0, 1'b0);
      CCIFG[4] = 1'b1;
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t5_ccr5_pending", 16'(CCIFG), 16'h0010);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);

      // 6: reset coincident with the access cycle suppresses the strobe
      clear_sources();
      TAIFG = 1'b1; TAIE = 1'b1;
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t6_taifg_kept", 16'(TAIFG), 16'h0001);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);

      // Random traffic with asynchronous flag arrivals and occasional resets
      clear_sources();
      CCIE = 6'b111111; TAIE = 1'b1;
      run = 0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 4) == 0) CCIFG = CCIFG | 6'(1 << $urandom_range(0, 5));
         if ($urandom_range(0, 9) == 0) TAIFG = 1'b1;
         if ($urandom_range(0, 40) == 0) CCIE = 6'($urandom);
         if ($urandom_range(0, 40) == 0) TAIE = 1'($urandom);
         if (run == 0 && $urandom_range(0, 2) == 0) run = $urandom_range(1, 4);
         m = (run > 0);
         if (run > 0) run--;
         cycle(m, ($urandom_range(0, 70) == 0), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
